// File: rtl/dm_write_buffer.sv
// Posted-write buffer between the CPU data port and a slow handshaked memory; optional load forwarding under WB_FORWARD_EN.
// Stores retire in the cycle they are presented. Loads take one issue cycle plus the memory handshake, or zero cycles on a forward hit.
// dm_stall holds the CPU while the queue is full with no drain ack, or while a load waits for its data.
module dm_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dm_write,
    input  logic          dm_read,
    input  logic [AW-1:0] write_address_to_dm,
    input  logic [AW-1:0] read_address_to_dm,
    input  logic [DW-1:0] data_to_dm,
    output logic [DW-1:0] data_from_dm,
    output logic          dm_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = AW - 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RDONE = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic [WW-1:0]  ent_addr_q [DEPTH];
    logic [DW-1:0]  ent_data_q [DEPTH];
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DW-1:0]  data_from_dm_q;
    logic           wr_done_q, wr_done_d;

    logic [PTR_W-1:0] head_idx, tail_idx;
    logic [WW-1:0]    rd_word, wr_word;
    logic             empty, full;
    logic             drain_ack, wr_pending, push, pop;
    logic             fwd_hit, load_ok;

    // Byte offsets play no part in matching or in the memory address.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{write_address_to_dm[1:0], read_address_to_dm[1:0]};

    assign head_idx = rd_ptr_q[PTR_W-1:0];
    assign tail_idx = wr_ptr_q[PTR_W-1:0];
    assign rd_word  = read_address_to_dm[AW-1:2];
    assign wr_word  = write_address_to_dm[AW-1:2];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign drain_ack = (state_q == S_WRITE) && mem_ack;
    assign pop       = drain_ack;

    // A store presented together with a stalled load is taken once; the CPU keeps
    // dm_write high until dm_stall drops, so wr_done_q masks the repeats.
    assign wr_pending = dm_write && !wr_done_q;
    assign push       = wr_pending && (!full || drain_ack);

    assign dm_stall = (wr_pending && full && !drain_ack) ||
                      (dm_read && (state_q != S_RDONE) && !fwd_hit);

    assign wr_done_d = dm_stall && (wr_done_q || push);

`ifdef WB_FORWARD_EN
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] fwd_idx;
    logic             fwd_match;
    logic [DW-1:0]    fwd_dat;

    assign count = wr_ptr_q - rd_ptr_q;

    // Scan oldest to youngest so the youngest matching entry wins; the store arriving this cycle is younger still.
    always_comb begin
        fwd_match = 1'b0;
        fwd_dat   = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_idx + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (ent_addr_q[fwd_idx] == rd_word)) begin
                fwd_match = 1'b1;
                fwd_dat   = ent_data_q[fwd_idx];
            end
        end
        if (push && (wr_word == rd_word)) begin
            fwd_match = 1'b1;
            fwd_dat   = data_to_dm;
        end
    end

    // Hits are taken only when no memory read is already in flight for this load.
    assign fwd_hit = dm_read && fwd_match && ((state_q == S_IDLE) || (state_q == S_WRITE));
    // A miss may bypass queued stores, but never a store the CPU has not yet handed over.
    assign load_ok = dm_read && !fwd_hit && !(wr_pending && !push);
`else
    assign fwd_hit = 1'b0;
    // Without forwarding a load must see every earlier store land in memory first.
    assign load_ok = dm_read && empty && !push;
`endif

    // Next-state logic: loads take priority over draining; address/data are captured at issue and held.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (load_ok) begin
                    state_d    = S_READ;
                    mem_addr_d = {rd_word, 2'b00};
                end else if (!empty) begin
                    state_d     = S_WRITE;
                    mem_addr_d  = {ent_addr_q[head_idx], 2'b00};
                    mem_wdata_d = ent_data_q[head_idx];
                end
            end
            S_WRITE: if (mem_ack) state_d = S_IDLE;
            S_READ:  if (mem_ack) state_d = S_RDONE;
            S_RDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, queue pointers and the memory-side address/data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wr_done_q   <= wr_done_d;
            if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Entry storage needs no reset: validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[tail_idx] <= wr_word;
            ent_data_q[tail_idx] <= data_to_dm;
        end
    end

    // Load data register: updated only when a load completes (memory or forward).
    always_ff @(posedge clk) begin
        if (reset) begin
            data_from_dm_q <= '0;
        end else if ((state_q == S_READ) && mem_ack) begin
            data_from_dm_q <= mem_rdata;
        end
`ifdef WB_FORWARD_EN
        else if (fwd_hit) begin
            data_from_dm_q <= fwd_dat;
        end
`endif
    end

    assign mem_req      = (state_q == S_WRITE) || (state_q == S_READ);
    assign mem_we       = (state_q == S_WRITE);
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign data_from_dm = data_from_dm_q;

endmodule

// File: tb/tb_dm_write_buffer.sv
// Testbench for dm_write_buffer: directed scenarios then randomized store/load traffic
// against a program-order memory model and a slow memory responder with random ack delay.
// Honors WB_FORWARD_EN when the design is built with it.
module tb_dm_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dm_write, dm_read;
    logic [31:0] write_address_to_dm, read_address_to_dm, data_to_dm;
    logic [31:0] data_from_dm;
    logic        dm_stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dm_write_buffer #(.DEPTH(4), .PTR_W(2), .DW(32), .AW(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .dm_write            (dm_write),
        .dm_read             (dm_read),
        .write_address_to_dm (write_address_to_dm),
        .read_address_to_dm  (read_address_to_dm),
        .data_to_dm          (data_to_dm),
        .data_from_dm        (data_from_dm),
        .dm_stall            (dm_stall),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wexp_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: committed memory, program-order view, and writes still owed to memory.
    logic [31:0] mem_arr [int unsigned];
    logic [31:0] shadow  [int unsigned];
    wexp_t       exp_wq[$];

    // Memory responder state.
    logic        ack_en;
    int          ack_delay;
    logic        busy, req_we;
    logic [31:0] req_addr, req_wdata;
    int          wait_cnt;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        ld_active;
    logic [31:0] ld_addr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int unsigned w);
        return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input int unsigned w);
        if (mem_arr.exists(w)) return mem_arr[w];
        return init_val(w);
    endfunction

    function automatic logic [31:0] exp_rd(input int unsigned w);
        if (shadow.exists(w)) return shadow[w];
        return mem_rd(w);
    endfunction

    // Slow memory: acks after wait_cnt cycles of a request, checks ordering and request stability.
    initial begin : mem_model
        wexp_t e;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        busy      = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_ack = 1'b0;
                busy    = 1'b0;
            end else if (mem_ack) begin
                if (req_we) begin
                    if (exp_wq.size() > 0) e = exp_wq.pop_front();
                    else e = wexp_t'{a: 32'hFFFF_FFFF, d: 32'hFFFF_FFFF};
                    chk("wr_addr", req_addr, e.a);
                    chk("wr_data", req_wdata, e.d);
                    mem_arr[req_addr >> 2] = req_wdata;
                    wr_cnt++;
                end else begin
                    rd_cnt++;
`ifndef WB_FORWARD_EN
                    chk("rd_after_drain", exp_wq.size(), 0);
`endif
                end
                mem_ack = 1'b0;
                busy    = 1'b0;
                chk("req_gap", mem_req, 0);
            end else if (mem_req) begin
                if (!busy) begin
                    busy      = 1'b1;
                    req_we    = mem_we;
                    req_addr  = mem_addr;
                    req_wdata = mem_wdata;
                    wait_cnt  = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                    chk("addr_align", mem_addr[1:0], 0);
                    if (!mem_we && ld_active) chk("rd_addr", mem_addr, {ld_addr[31:2], 2'b00});
                end else begin
                    chk("hold_addr", {mem_we, mem_addr}, {req_we, req_addr});
                    if (req_we) chk("hold_data", mem_wdata, req_wdata);
                end
                if (ack_en) begin
                    if (wait_cnt == 0) begin
                        mem_ack = 1'b1;
                        if (!req_we) mem_rdata = mem_rd(req_addr >> 2);
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // All CPU tasks start and end at posedge+1.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit expect_free);
        dm_write            = 1'b1;
        write_address_to_dm = a;
        data_to_dm          = d;
        @(negedge clk);
        if (expect_free) chk("st_nostall", dm_stall, 0);
        for (int c = 0; c < 300 && dm_stall; c++) @(negedge clk);
        chk("st_timeout", dm_stall, 0);
        @(posedge clk);
        exp_wq.push_back(wexp_t'{a: {a[31:2], 2'b00}, d: d});
        shadow[a >> 2] = d;
        #1;
        dm_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output int stalls);
        ld_active          = 1'b1;
        ld_addr            = a;
        dm_read            = 1'b1;
        read_address_to_dm = a;
        stalls             = 0;
        @(negedge clk);
        for (int c = 0; c < 300 && dm_stall; c++) begin
            stalls++;
            @(negedge clk);
        end
        chk("ld_timeout", dm_stall, 0);
        @(posedge clk);
        #1;
        dm_read   = 1'b0;
        ld_active = 1'b0;
        chk("ld_data", data_from_dm, exp_rd(a >> 2));
    endtask

    // Store and load together; the buffer is drained beforehand so the store is taken on the first edge.
    task automatic do_both(input logic [31:0] a, input logic [31:0] d);
        logic stalled;
        ld_active           = 1'b1;
        ld_addr             = a;
        dm_write            = 1'b1;
        dm_read             = 1'b1;
        write_address_to_dm = a;
        read_address_to_dm  = a;
        data_to_dm          = d;
        @(negedge clk);
        stalled = dm_stall;
        @(posedge clk);
        exp_wq.push_back(wexp_t'{a: {a[31:2], 2'b00}, d: d});
        shadow[a >> 2] = d;
        if (stalled) begin
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (!dm_stall) break;
            end
            chk("both_timeout", dm_stall, 0);
            @(posedge clk);
        end
        #1;
        dm_write  = 1'b0;
        dm_read   = 1'b0;
        ld_active = 1'b0;
        chk("both_data", data_from_dm, exp_rd(a >> 2));
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (exp_wq.size() == 0 && !mem_req && !mem_ack) break;
        end
        chk("drain", exp_wq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int w0, r0, st;
        logic [31:0] a, d;
        reset               = 1'b1;
        dm_write            = 1'b0;
        dm_read             = 1'b0;
        write_address_to_dm = '0;
        read_address_to_dm  = '0;
        data_to_dm          = '0;
        ack_en              = 1'b1;
        ack_delay           = 3;
        ld_active           = 1'b0;
        ld_addr             = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", data_from_dm, 0);
        chk("rst_stall", dm_stall, 0);

        // Single store, 3-cycle ack
        w0 = wr_cnt;
        do_store(32'h10, 32'hDEAD_BEEF, 1'b1);
        wait_drain();
        chk("single_wr_cnt", wr_cnt - w0, 1);

        // Fill the queue with ack held low; the fifth store waits for the first drain ack
        ack_en    = 1'b0;
        ack_delay = 0;
        w0        = wr_cnt;
        for (int i = 0; i < 4; i++) do_store(32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1);
        dm_write            = 1'b1;
        write_address_to_dm = 32'h10;
        data_to_dm          = 32'hC0DE_0004;
        @(negedge clk);
        chk("full_stall_a", dm_stall, 1);
        @(negedge clk);
        chk("full_stall_b", dm_stall, 1);
        ack_en = 1'b1;
        @(negedge clk);
        chk("full_accept", dm_stall, 0);
        @(posedge clk);
        exp_wq.push_back(wexp_t'{a: 32'h10, d: 32'hC0DE_0004});
        shadow[32'h10 >> 2] = 32'hC0DE_0004;
        #1;
        dm_write = 1'b0;
        wait_drain();
        chk("fill_wr_cnt", wr_cnt - w0, 5);

        // Load from memory with 2-cycle ack delay: IDLE issue cycle plus three READ cycles
        ack_delay      = 2;
        mem_arr[32'h8] = 32'h1234_5678;
        r0             = rd_cnt;
        do_load(32'h20, st);
        chk("ld20_value", data_from_dm, 32'h1234_5678);
        chk("ld20_stalls", st, 4);
        chk("ld20_reads", rd_cnt - r0, 1);

        // Store then load of the same word with a different byte offset
`ifdef WB_FORWARD_EN
        ack_en = 1'b0;
        r0     = rd_cnt;
        do_store(32'h40, 32'hAAAA_5555, 1'b1);
        do_load(32'h43, st);
        chk("fwd_stalls", st, 0);
        chk("fwd_no_read", rd_cnt - r0, 0);
        ack_en = 1'b1;
        wait_drain();
`else
        r0 = rd_cnt;
        do_store(32'h40, 32'hAAAA_5555, 1'b1);
        do_load(32'h43, st);
        chk("ld43_reads", rd_cnt - r0, 1);
        wait_drain();
`endif
        chk("ld43_value", data_from_dm, 32'hAAAA_5555);

        // Reset while draining with three stores queued
        ack_en = 1'b0;
        do_store(32'h60, 32'h1111_0001, 1'b1);
        do_store(32'h64, 32'h1111_0002, 1'b1);
        do_store(32'h68, 32'h1111_0003, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_req", mem_req, 1);
        reset = 1'b1;
        @(posedge clk);
        exp_wq.delete();
        shadow = mem_arr;
        #1;
        reset = 1'b0;
        chk("rst_abandon_req", mem_req, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fifo_empty", mem_req, 0);
        ack_en    = 1'b1;
        ack_delay = 1;
        w0        = wr_cnt;
        do_store(32'h80, 32'h0000_0080, 1'b1);
        wait_drain();
        chk("post_rst_wr_cnt", wr_cnt - w0, 1);

        // Simultaneous store and load to the same word
        do_both(32'h50, 32'h0000_0077);
        chk("both_value", data_from_dm, 32'h0000_0077);
        wait_drain();

        // Randomized traffic over a small address window to provoke matches and full queues
        ack_delay = -1;
        for (int n = 0; n < 150; n++) begin
            a = 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            d = $urandom;
            case ($urandom_range(0, 4))
                0, 1, 2: do_store(a, d, 1'b0);
                3:       do_load(a, st);
                default: begin
                    wait_drain();
                    do_both(a, d);
                end
            endcase
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #0;
        end
        wait_drain();
        for (int wd = 32'h40; wd < 32'h48; wd++) begin
            if (shadow.exists(wd)) chk("final_mem", mem_rd(wd), shadow[wd]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
